// File: rtl/spi_alu_pkg.sv
// Shared types and constants for the SPI-driven 4-bit ALU front end.
package spi_alu_pkg;

    localparam int         FRAME_BITS  = 12;
    localparam logic [3:0] TX_SYNC     = 4'b1010;
    localparam logic [3:0] BIT_CNT_SAT = 4'd13;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_PASSA = 4'd8,
        OP_PASSB = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic ovf;
        logic op_err;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_EXEC
    } state_e;

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit ALU; opcodes outside the defined set report op_err only.
module alu4
    import spi_alu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] result,
    output logic [3:0] flags
);

    logic [4:0] wide;
    alu_flags_t f;

    always_comb begin
        wide = 5'd0;
        f    = '0;
        case (op)
            OP_ADD:   wide = {1'b0, a} + {1'b0, b};
            OP_SUB:   wide = {1'b0, a} - {1'b0, b};
            OP_AND:   wide = {1'b0, a & b};
            OP_OR:    wide = {1'b0, a | b};
            OP_XOR:   wide = {1'b0, a ^ b};
            OP_NOT:   wide = {1'b0, ~a};
            OP_SHL:   wide = {1'b0, a << b[1:0]};
            OP_SHR:   wide = {1'b0, a >> b[1:0]};
            OP_PASSA: wide = {1'b0, a};
            OP_PASSB: wide = {1'b0, b};
            default:  f.op_err = 1'b1;
        endcase
        // Bit 4 of the 5-bit difference is the borrow for SUB
        if (op == OP_ADD || op == OP_SUB) f.carry = wide[4];
        if (op == OP_ADD) f.ovf = (a[3] == b[3]) && (wide[3] != a[3]);
        if (op == OP_SUB) f.ovf = (a[3] != b[3]) && (wide[3] != a[3]);
        f.zero = !f.op_err && (wide[3:0] == 4'd0);
    end

    assign result = wide[3:0];
    assign flags  = f;

endmodule

// File: rtl/spi_alu_frontend.sv
// Mode-0 SPI slave oversampled in clk: takes 12-bit {op,A,B} frames, latches the
// ALU result for the PWM stage and returns the previous result/flags on MISO.
module spi_alu_frontend
    import spi_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic [3:0] alu_out,
    output logic [3:0] flags,
    output logic       result_valid,
    output logic       frame_err
);

    // [1:0] are the synchronizer stages, [2] is the delayed copy for edge detect
    logic [2:0]            sclk_sync_q, sclk_sync_d;
    logic [2:0]            cs_n_sync_q, cs_n_sync_d;
    logic [1:0]            mosi_sync_q, mosi_sync_d;
    state_e                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [3:0]            alu_out_q, alu_out_d;
    alu_flags_t            flags_q, flags_d;
    logic                  result_valid_q, result_valid_d;
    logic                  frame_err_q, frame_err_d;

    logic       sclk_rise, sclk_fall, cs_rise, cs_low;
    logic [3:0] alu_res;
    alu_flags_t alu_flg;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_rise   = cs_n_sync_q[1] & ~cs_n_sync_q[2];
    assign cs_low    = ~cs_n_sync_q[1];

    alu4 u_alu (
        .op     (rx_q[11:8]),
        .a      (rx_q[7:4]),
        .b      (rx_q[3:0]),
        .result (alu_res),
        .flags  (alu_flg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q    <= 3'b000;
            cs_n_sync_q    <= 3'b111;
            mosi_sync_q    <= 2'b00;
            state_q        <= ST_IDLE;
            bit_cnt_q      <= 4'd0;
            rx_q           <= '0;
            tx_q           <= '0;
            alu_out_q      <= 4'd0;
            flags_q        <= '0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            sclk_sync_q    <= sclk_sync_d;
            cs_n_sync_q    <= cs_n_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_q           <= rx_d;
            tx_q           <= tx_d;
            alu_out_q      <= alu_out_d;
            flags_q        <= flags_d;
            result_valid_q <= result_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    // IDLE is level-sensitive so a cs_n fall that lands during EXEC is still taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cs_low) state_d = ST_SHIFT;
            ST_SHIFT: if (cs_rise)
                          state_d = (bit_cnt_q == 4'(FRAME_BITS)) ? ST_EXEC : ST_IDLE;
            ST_EXEC:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sclk_sync_d    = {sclk_sync_q[1:0], sclk};
        cs_n_sync_d    = {cs_n_sync_q[1:0], cs_n};
        mosi_sync_d    = {mosi_sync_q[0], mosi};
        bit_cnt_d      = bit_cnt_q;
        rx_d           = rx_q;
        tx_d           = tx_q;
        alu_out_d      = alu_out_q;
        flags_d        = flags_q;
        result_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: if (cs_low) begin
                bit_cnt_d = 4'd0;
                tx_d      = {TX_SYNC, flags_q, alu_out_q};
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    rx_d = {rx_q[FRAME_BITS-2:0], mosi_sync_q[1]};
                    if (bit_cnt_q != BIT_CNT_SAT) bit_cnt_d = bit_cnt_q + 4'd1;
                end
                if (sclk_fall) tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                if (cs_rise && bit_cnt_q != 4'(FRAME_BITS)) frame_err_d = 1'b1;
            end
            ST_EXEC: begin
                result_valid_d = 1'b1;
                flags_d        = alu_flg;
                if (!alu_flg.op_err) alu_out_d = alu_res;
            end
            default: ;
        endcase
    end

    assign miso         = (state_q == ST_SHIFT) && tx_q[FRAME_BITS-1];
    assign alu_out      = alu_out_q;
    assign flags        = flags_q;
    assign result_valid = result_valid_q;
    assign frame_err    = frame_err_q;

endmodule
